// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one fp_adder between NUM_REQ requesters,
// with start/done sequencing, a drain phase and a watchdog on a hung adder.
module fp_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0]   req_sub,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   resp_valid,
   output logic [31:0]          resp_result,
   output logic                 resp_overflow,
   output logic                 resp_underflow,
   output logic                 resp_error,
   output logic                 busy,
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   output logic                 add_sub,
   output logic                 add_start,
   input  logic [31:0]          add_result,
   input  logic                 add_done,
   input  logic                 add_overflow,
   input  logic                 add_underflow
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
   state_t state;
   logic [IDX_W-1:0] rr_ptr, cur, pick;
   logic [IDX_W:0] sel;
   logic hit;
   logic [CW-1:0] cnt;
   // Walk offsets downward so the smallest offset from rr_ptr wins.
   always_comb begin
      pick = '0;
      hit = 1'b0;
      sel = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sel = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (sel >= (IDX_W+1)'(NUM_REQ)) sel = sel - (IDX_W+1)'(NUM_REQ);
         if (req_valid[sel[IDX_W-1:0]]) begin
            hit = 1'b1;
            pick = sel[IDX_W-1:0];
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         rr_ptr <= '0;
         cur <= '0;
         cnt <= '0;
         req_ready <= '0;
         resp_valid <= '0;
         resp_result <= '0;
         resp_overflow <= 1'b0;
         resp_underflow <= 1'b0;
         resp_error <= 1'b0;
         busy <= 1'b0;
         add_a <= '0;
         add_b <= '0;
         add_sub <= 1'b0;
         add_start <= 1'b0;
      end else begin
         req_ready <= '0;
         resp_valid <= '0;
         case (state)
            IDLE: if (hit) begin
               add_a <= req_a[{pick, 5'd0} +: 32];
               add_b <= req_b[{pick, 5'd0} +: 32];
               add_sub <= req_sub[pick];
               req_ready <= NUM_REQ'(1) << pick;
               add_start <= 1'b1;
               cnt <= '0;
               cur <= pick;
               rr_ptr <= (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
               busy <= 1'b1;
               state <= WAIT;
            end
            WAIT: if (add_done) begin
               resp_result <= add_result;
               resp_overflow <= add_overflow;
               resp_underflow <= add_underflow;
               resp_error <= 1'b0;
               resp_valid <= NUM_REQ'(1) << cur;
               add_start <= 1'b0;
               state <= DRAIN;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               resp_result <= 32'h7FC0_0000;
               resp_overflow <= 1'b0;
               resp_underflow <= 1'b0;
               resp_error <= 1'b1;
               resp_valid <= NUM_REQ'(1) << cur;
               add_start <= 1'b0;
               state <= DRAIN;
            end else begin
               cnt <= cnt + 1'b1;
            end
            // Hold off the next start until the adder has dropped done.
            DRAIN: if (!add_done) begin
               state <= IDLE;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed and randomized checks of fp_add_arbiter against a
// transaction-level timing model, with a behavioural 3-cycle adder stand-in.
module tb_fp_add_arbiter;
   localparam int N = 4;
   localparam int IW = 2;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0] req_valid = '0, req_sub = '0, req_ready, resp_valid;
   logic [32*N-1:0] req_a = '0, req_b = '0;
   logic [31:0] resp_result, add_a, add_b, add_result;
   logic resp_overflow, resp_underflow, resp_error, busy, add_sub, add_start;
   logic add_done, add_overflow, add_underflow;
   logic hang = 1'b0;
   int tests = 0, fails = 0;
   int cyc = 0, ptr = 0, g = -100, ok = 0, lat = 4, cur = 0, mode = 0;
   bit pending = 1'b0;
   logic [31:0] ea = '0, eb = '0, er = '0;
   logic es = 1'b0, eo = 1'b0, eu = 1'b0, ee = 1'b0;
   int seen[$], rseen[$];
   int hi_n, lo_n;

   always #5 clk = ~clk;

   fp_add_arbiter #(.NUM_REQ(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_sub(req_sub), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_result(resp_result), .resp_overflow(resp_overflow),
      .resp_underflow(resp_underflow), .resp_error(resp_error), .busy(busy),
      .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_start(add_start),
      .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow),
      .add_underflow(add_underflow)
   );

   function automatic real to_real(input logic [31:0] x);
      logic [10:0] e;
      if (x[30:0] == 31'd0) return 0.0;
      e = 11'(x[30:23]) + 11'd896;
      return $bitstoreal({x[31], e, x[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] to_single(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fp(input logic [31:0] a, input logic [31:0] b, input logic s);
      return to_single(s ? to_real(a) - to_real(b) : to_real(a) + to_real(b));
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
   endfunction

   // Adder stand-in: done rises three edges after start is first seen, and
   // falls after two edges of start low. Flags are arbitrary operand parities.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         add_done <= 1'b0;
         add_result <= '0;
         add_overflow <= 1'b0;
         add_underflow <= 1'b0;
         hi_n <= 0;
         lo_n <= 0;
      end else if (add_start) begin
         lo_n <= 0;
         if (!hang) begin
            hi_n <= hi_n + 1;
            if (hi_n == 2) begin
               add_done <= 1'b1;
               add_result <= fp(add_a, add_b, add_sub);
               add_overflow <= ^add_a[3:0];
               add_underflow <= ^add_b[3:0];
            end
         end
      end else begin
         hi_n <= 0;
         if (add_done) begin
            lo_n <= lo_n + 1;
            if (lo_n == 1) begin
               add_done <= 1'b0;
               lo_n <= 0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic chk_zero();
      check("rst_ctrl", {req_ready, resp_valid, busy, add_start, resp_error,
                         resp_overflow, resp_underflow, add_sub}, 32'd0);
      check("rst_result", resp_result, 32'd0);
      check("rst_add_a", add_a, 32'd0);
      check("rst_add_b", add_b, 32'd0);
   endtask

   // Spec-level timing: response lat cycles after a grant; the next grant is
   // possible 8 cycles after a normal grant, lat+2 after a watchdog abort.
   task automatic observe();
      logic [N-1:0] xr, xv;
      int k;
      xr = '0;
      xv = '0;
      k = -1;
      if (pending && cyc == g + lat) begin
         xv[cur] = 1'b1;
         pending = 1'b0;
         if (lat == 4) begin
            er = fp(ea, eb, es); eo = ^ea[3:0]; eu = ^eb[3:0]; ee = 1'b0;
         end else begin
            er = 32'h7FC0_0000; eo = 1'b0; eu = 1'b0; ee = 1'b1;
         end
      end
      if (cyc >= ok && req_valid != '0) begin
         for (int o = 0; o < N; o++)
            if (k < 0 && req_valid[(ptr + o) % N]) k = (ptr + o) % N;
         xr[k] = 1'b1;
         g = cyc;
         cur = k;
         ea = req_a[32*k +: 32];
         eb = req_b[32*k +: 32];
         es = req_sub[k];
         lat = hang ? TO : 4;
         ok = g + lat + (hang ? 2 : 4);
         ptr = (k + 1) % N;
         pending = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         if (req_ready[i]) seen.push_back(i);
         if (resp_valid[i]) rseen.push_back(i);
      end
      check("req_ready", req_ready, xr);
      check("resp_valid", resp_valid, xv);
      check("busy", busy, 32'(cyc >= g && cyc < ok - 1));
      check("add_start", add_start, 32'(pending && cyc >= g && cyc < g + lat));
      check("add_a", add_a, ea);
      check("add_b", add_b, eb);
      check("add_sub", add_sub, es);
      check("resp_result", resp_result, er);
      check("resp_flags", {resp_overflow, resp_underflow, resp_error}, {eo, eu, ee});
   endtask

   task automatic raise(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      req_valid[i] = 1'b1;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_sub[i] = s;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (req_ready[i] && mode != 1) req_valid[i] = 1'b0;
         if (mode == 2) begin
            if (!req_valid[i] && $urandom_range(0, 5) == 0)
               raise(i, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
            else if (req_valid[i] && !req_ready[i] && $urandom_range(0, 40) == 0)
               req_valid[i] = 1'b0;
         end
      end
      if (mode == 2 && !pending && cyc >= ok - 1 && $urandom_range(0, 9) == 0) hang = ~hang;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         observe();
         drive();
      end
   endtask

   task automatic do_reset(input logic [N-1:0] keep);
      reset = 1'b1;
      #1;
      chk_zero();
      req_valid = keep;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      reset = 1'b0;
      pending = 1'b0; ptr = 0; g = -100; ok = 0; hang = 1'b0;
      ea = '0; eb = '0; es = 1'b0; er = '0; eo = 1'b0; eu = 1'b0; ee = 1'b0;
   endtask

   initial begin
      int order[5] = '{0, 1, 2, 3, 0};
      int n1;
      @(negedge clk);
      chk_zero();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      mode = 0;
      raise(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
      run(1);
      check("t1_grant", req_ready, 32'h1);
      run(4);
      check("t1_resp", resp_valid, 32'h1);
      check("t1_result", resp_result, 32'h4040_0000);
      check("t1_error", resp_error, 32'd0);
      run(6);
      raise(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
      run(5);
      check("t2_resp", resp_valid, 32'h4);
      check("t2_result", resp_result, 32'h4000_0000);
      run(3);
      check("t2_busy", busy, 32'd0);
      run(4);
      do_reset('0);
      mode = 1;
      for (int i = 0; i < N; i++) raise(i, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
      seen.delete();
      run(38);
      for (int i = 0; i < 5; i++) check("t3_order", seen.size() > i ? seen[i] : -1, order[i]);
      mode = 0;
      req_valid = '0;
      run(12);
      hang = 1'b1;
      raise(1, rand_fp(), rand_fp(), 1'b0);
      run(17);
      check("t4_resp", resp_valid, 32'h2);
      check("t4_error", resp_error, 32'd1);
      check("t4_result", resp_result, 32'h7FC0_0000);
      run(1);
      check("t4_busy", busy, 32'd0);
      check("t4_start", add_start, 32'd0);
      run(4);
      hang = 1'b0;
      raise(0, rand_fp(), rand_fp(), 1'b0);
      run(3);
      raise(3, rand_fp(), rand_fp(), 1'b1);
      do_reset(4'b1000);
      run(1);
      check("t5_grant", req_ready, 32'h8);
      run(10);
      raise(0, rand_fp(), rand_fp(), 1'b1);
      run(2);
      raise(1, rand_fp(), rand_fp(), 1'b0);
      seen.delete();
      rseen.delete();
      run(2);
      req_valid[1] = 1'b0;
      run(12);
      n1 = 0;
      foreach (seen[i]) if (seen[i] == 1) n1++;
      foreach (rseen[i]) if (rseen[i] == 1) n1++;
      check("t6_withdrawn", n1, 32'd0);
      mode = 2;
      run(3000);
      mode = 0;
      req_valid = '0;
      run(30);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fp_adder instance between NUM_REQ independent requesters.
- Latches a granted request's operands and drives the adder's start/done handshake, including holding start and waiting for done to clear.
- Returns result and flags to the winning requester, with a watchdog on a hung adder.
- Sits between the calculator's operation dispatch logic and the single floating-point add/sub datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of requester index; must equal ceil(log2(NUM_REQ)).
- TIMEOUT, 64, maximum cycles spent in WAIT before the operation is aborted with resp_error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high with stable operands until req_ready.
- req_a  in  32*NUM_REQ  operand A; slot k at [32k+31:32k].
- req_b  in  32*NUM_REQ  operand B, same packing.
- req_sub  in  NUM_REQ  1 = subtract, 0 = add.
- req_ready  out  NUM_REQ  one-hot, one-cycle grant; operands latched on this cycle's edge.
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- resp_result  out  32  result of the last completed operation.
- resp_overflow  out  1  adder overflow flag for the last completed operation.
- resp_underflow  out  1  adder underflow flag for the last completed operation.
- resp_error  out  1  1 = last operation aborted by the watchdog.
- busy  out  1  high in every state except IDLE.
- add_a  out  32  to adder a.
- add_b  out  32  to adder b.
- add_sub  out  1  to adder sub.
- add_start  out  1  to adder start.
- add_result  in  32  from adder result.
- add_done  in  1  from adder done.
- add_overflow  in  1  from adder overflow.
- add_underflow  in  1  from adder underflow.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, timeout counter 0.
- Reset mid-operation abandons the operation: no response is issued and add_start drops immediately. The adder shares the same reset.
- States: IDLE, WAIT, DRAIN. All outputs are registered.
- IDLE:
  - If any req_valid is set, select the first set bit searching upward from rr_ptr, modulo NUM_REQ. Call it k.
  - At the edge: latch slot k into add_a, add_b, add_sub; set req_ready[k]=1 for one cycle; set add_start=1; clear the counter; set rr_ptr=(k+1) mod NUM_REQ; go to WAIT.
  - With no request set: stay in IDLE; add_start stays 0.
- WAIT: add_start stays high and operands stay stable.
  - If add_done=1 at the edge:
    - Capture add_result, add_overflow and add_underflow into resp_result, resp_overflow and resp_underflow.
    - Set resp_error=0 and resp_valid[k]=1 for one cycle; set add_start=0; go to DRAIN.
  - Else if the counter reaches TIMEOUT-1:
    - Set resp_result=0x7FC00000, resp_overflow=0, resp_underflow=0, resp_error=1, resp_valid[k]=1; set add_start=0; go to DRAIN.
  - Else increment the counter.
- DRAIN: add_start=0. Go to IDLE on the first edge that samples add_done=0. This guarantees the adder has returned to its idle state before the next start.
- Latency with the 3-cycle adder:
  - req_ready after edge E0; adder enters COMPUTE at E1 and DONE at E2; add_done goes high after E3.
  - resp_valid after E4 (four cycles after the grant).
  - DRAIN exits at E7, so a new grant is possible at E8.
- Request rules:
  - A requester may drop req_valid before it is granted; it is then never granted.
  - Requests arriving while busy wait; grants are issued only from IDLE.
  - A requester may reassert req_valid in the same cycle its resp_valid is high.
- resp_result and flags hold their value until the next response.
- Exactly one bit of req_ready is set at a time, or none; the same holds for resp_valid.

Test Plan:
- Single request, add: requester 0 issues 0x3F800000 + 0x40000000, sub=0 -> req_ready=0001 after E0, add_start high E0..E4, resp_valid=0001 after E4 with resp_result=0x40400000, resp_error=0.
- Single request, subtract: requester 2 issues 0x40400000 - 0x3F800000 -> resp_valid=0100, resp_result=0x40000000; busy falls after DRAIN exits.
- Fairness: all four req_valid held continuously -> grant order 0,1,2,3,0 with no requester granted twice before the others; after reset the first grant goes to requester 0.
- Watchdog: TIMEOUT=16, add_done tied 0 -> resp_valid after 16 WAIT cycles with resp_error=1 and resp_result=0x7FC00000; add_start low from then on; DRAIN exits immediately.
- Reset mid-operation: assert reset during WAIT -> all outputs 0 asynchronously and no resp_valid. After release, a pending request from requester 3 is granted (rr_ptr back to 0, search reaches 3).
- Withdrawn request: requester 1 pulses req_valid while the arbiter is busy and drops it before IDLE -> no req_ready[1] and no resp_valid[1].
